// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between the in-order WB stage (A) and the
// multi-cycle unit (B), and tracks pending B destinations for decode hazard checks.
module regfile_wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clock,
  input  logic        Reset,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic [4:0]  rd_addr,
  output logic        hazard,
  output logic        pipe_stall,
  output logic        write_sig,
  output logic [4:0]  d_addr,
  output logic [31:0] writeback_data,
  output logic        starve_state
);

  // B handshake: a result transfers on a cycle where b_valid and b_ready are both
  // high; b_ready depends only on buffer occupancy, never on b_valid.

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [SW-1:0] SAT_CNT  = SW'(STARVE_LIMIT - 1);

  typedef enum logic {
    NORMAL = 1'b0,
    STALL  = 1'b1
  } state_t;

  state_t        state, state_next;
  logic [SW-1:0] starve_cnt, starve_cnt_next;

  logic [4:0]    mem_addr [DEPTH];
  logic [31:0]   mem_data [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;

  logic [31:0]   pending, pending_next;

  logic          empty, push, pop, sel_valid;
  logic [4:0]    head_addr, sel_addr;
  logic [31:0]   sel_data;

  assign empty     = (count == '0);
  assign b_ready   = (count != FULL_CNT);
  assign push      = b_valid & b_ready;
  assign pop       = ~a_valid & ~empty;
  assign head_addr = mem_addr[rd_ptr];
  assign sel_valid = a_valid | pop;
  assign sel_addr  = a_valid ? a_addr : head_addr;
  assign sel_data  = a_valid ? a_data : mem_data[rd_ptr];

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CW'(1);
    else if (pop && !push)
      count_next = count - CW'(1);
  end

  // Storage carries no reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_addr[wr_ptr] <= b_addr;
      mem_data[wr_ptr] <= b_data;
    end
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_next;
    end
  end

  // Issue is applied after the commit clear so a same-edge set on the same bit wins.
  always_comb begin
    pending_next = pending;
    if (pop)
      pending_next[head_addr] = 1'b0;
    if (issue_valid)
      pending_next[issue_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset)
      pending <= '0;
    else
      pending <= pending_next;
  end

  assign hazard = pending[rs_addr] | pending[rt_addr] | pending[rd_addr];

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      write_sig      <= 1'b0;
      d_addr         <= '0;
      writeback_data <= '0;
    end else if (sel_valid) begin
      write_sig      <= (sel_addr != 5'd0);
      d_addr         <= sel_addr;
      writeback_data <= sel_data;
    end else begin
      write_sig      <= 1'b0;
    end
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      state      <= NORMAL;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_cnt_next;
    end
  end

  // Counter saturates at the limit and is held there for the single stall cycle.
  always_comb begin
    state_next      = state;
    starve_cnt_next = starve_cnt;
    case (state)
      NORMAL: begin
        if (empty || pop)
          starve_cnt_next = '0;
        else if (a_valid) begin
          if (starve_cnt == SAT_CNT)
            state_next = STALL;
          else
            starve_cnt_next = starve_cnt + SW'(1);
        end
      end
      STALL: begin
        if (empty || pop) begin
          state_next      = NORMAL;
          starve_cnt_next = '0;
        end
      end
    endcase
  end

  assign pipe_stall   = (state == STALL);
  assign starve_state = state;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: each task drives one scenario and checks
// its outputs inline against hand-computed values.
module tb_regfile_wb_arbiter;

  logic        clock = 1'b0;
  logic        Reset;
  logic        a_valid, b_valid, issue_valid;
  logic [4:0]  a_addr, b_addr, issue_rd, rs_addr, rt_addr, rd_addr;
  logic [31:0] a_data, b_data;
  logic        b_ready, hazard, pipe_stall, write_sig, starve_state;
  logic [4:0]  d_addr;
  logic [31:0] writeback_data;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clock(clock), .Reset(Reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .hazard(hazard), .pipe_stall(pipe_stall), .write_sig(write_sig),
    .d_addr(d_addr), .writeback_data(writeback_data), .starve_state(starve_state)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0;
    issue_valid = 0; issue_rd = 0;
    rs_addr = 0; rt_addr = 0; rd_addr = 0;
  endtask

  task automatic test_reset();
    Reset = 1; idle_inputs();
    repeat (2) step();
    Reset = 0;
    step();
    checks++; if (write_sig !== 1'b0) begin errors++; $display("FAIL reset_write_sig got %b expected 0", write_sig); end
    checks++; if (d_addr !== 5'd0) begin errors++; $display("FAIL reset_d_addr got %0d expected 0", d_addr); end
    checks++; if (writeback_data !== 32'h0) begin errors++; $display("FAIL reset_wb_data got %h expected 0", writeback_data); end
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL reset_pipe_stall got %b expected 0", pipe_stall); end
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL reset_b_ready got %b expected 1", b_ready); end
    // Build 3 buffered B entries with A busy, and pending[4]=1.
    a_valid = 1; a_addr = 5'd1; a_data = 32'h1;
    issue_valid = 1; issue_rd = 5'd4;
    b_valid = 1; b_addr = 5'd2; b_data = 32'h100;
    step();
    issue_valid = 0; b_addr = 5'd3; b_data = 32'h101;
    step();
    b_addr = 5'd6; b_data = 32'h102;
    step();
    b_valid = 0; rs_addr = 5'd4;
    #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL pre_reset_hazard got %b expected 1", hazard); end
    checks++; if (write_sig !== 1'b1) begin errors++; $display("FAIL pre_reset_write_sig got %b expected 1", write_sig); end
    #2 Reset = 1;
    #1;
    checks++; if (write_sig !== 1'b0) begin errors++; $display("FAIL async_reset_write_sig got %b expected 0", write_sig); end
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL async_reset_b_ready got %b expected 1", b_ready); end
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL async_reset_hazard got %b expected 0", hazard); end
    checks++; if (starve_state !== 1'b0) begin errors++; $display("FAIL async_reset_state got %b expected 0", starve_state); end
    idle_inputs();
    step();
    Reset = 0;
    step();
    step();
    checks++; if (write_sig !== 1'b0) begin errors++; $display("FAIL reset_discard_write_sig got %b expected 0", write_sig); end
  endtask

  task automatic test_a_only();
    a_valid = 1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
    step();
    idle_inputs();
    checks++; if (write_sig !== 1'b1) begin errors++; $display("FAIL a_only_write_sig got %b expected 1", write_sig); end
    checks++; if (d_addr !== 5'd5) begin errors++; $display("FAIL a_only_d_addr got %0d expected 5", d_addr); end
    checks++; if (writeback_data !== 32'hDEADBEEF) begin errors++; $display("FAIL a_only_data got %h expected deadbeef", writeback_data); end
    step();
    checks++; if (write_sig !== 1'b0) begin errors++; $display("FAIL idle_write_sig got %b expected 0", write_sig); end
    checks++; if (d_addr !== 5'd5 || writeback_data !== 32'hDEADBEEF) begin errors++; $display("FAIL idle_hold got %0d/%h expected 5/deadbeef", d_addr, writeback_data); end
  endtask

  task automatic test_collision();
    a_valid = 1; a_addr = 5'd3; a_data = 32'h11;
    b_valid = 1; b_addr = 5'd7; b_data = 32'h22;
    step();
    idle_inputs();
    checks++; if (write_sig !== 1'b1 || d_addr !== 5'd3 || writeback_data !== 32'h11) begin errors++; $display("FAIL collision_a got %b/%0d/%h expected 1/3/11", write_sig, d_addr, writeback_data); end
    step();
    checks++; if (write_sig !== 1'b1 || d_addr !== 5'd7 || writeback_data !== 32'h22) begin errors++; $display("FAIL collision_b got %b/%0d/%h expected 1/7/22", write_sig, d_addr, writeback_data); end
    step();
    checks++; if (write_sig !== 1'b0) begin errors++; $display("FAIL collision_idle got %b expected 0", write_sig); end
  endtask

  task automatic test_r0_and_full();
    logic [4:0] addrs [4];
    addrs[0] = 5'd0; addrs[1] = 5'd10; addrs[2] = 5'd11; addrs[3] = 5'd13;
    a_valid = 1; a_addr = 5'd1; a_data = 32'hA;
    b_valid = 1;
    for (int i = 0; i < 4; i++) begin
      b_addr = addrs[i]; b_data = 32'h200 + i;
      step();
      if (i == 2) begin
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL three_entries_b_ready got %b expected 1", b_ready); end
      end
    end
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL full_b_ready got %b expected 0", b_ready); end
    idle_inputs();
    step();
    checks++; if (write_sig !== 1'b0) begin errors++; $display("FAIL r0_write_sig got %b expected 0", write_sig); end
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL r0_pop_b_ready got %b expected 1", b_ready); end
    for (int i = 1; i < 4; i++) begin
      step();
      checks++; if (write_sig !== 1'b1 || d_addr !== addrs[i] || writeback_data !== 32'h200 + i) begin errors++; $display("FAIL drain_%0d got %b/%0d/%h expected 1/%0d/%h", i, write_sig, d_addr, writeback_data, addrs[i], 32'h200 + i); end
    end
    step();
    checks++; if (write_sig !== 1'b0 || pipe_stall !== 1'b0) begin errors++; $display("FAIL drain_done got ws=%b stall=%b expected 0/0", write_sig, pipe_stall); end
  endtask

  task automatic test_starvation();
    a_valid = 1; a_addr = 5'd2; a_data = 32'h55;
    b_valid = 1; b_addr = 5'd9; b_data = 32'h99;
    step();
    b_valid = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++; if (pipe_stall !== (k == 8)) begin errors++; $display("FAIL starve_cycle_%0d got %b expected %b", k, pipe_stall, (k == 8)); end
    end
    checks++; if (starve_state !== 1'b1) begin errors++; $display("FAIL stall_state got %b expected 1", starve_state); end
    a_valid = 0;
    step();
    checks++; if (write_sig !== 1'b1 || d_addr !== 5'd9 || writeback_data !== 32'h99) begin errors++; $display("FAIL stall_write got %b/%0d/%h expected 1/9/99", write_sig, d_addr, writeback_data); end
    checks++; if (pipe_stall !== 1'b0 || starve_state !== 1'b0) begin errors++; $display("FAIL stall_exit got %b/%b expected 0/0", pipe_stall, starve_state); end
    step();
    checks++; if (write_sig !== 1'b0) begin errors++; $display("FAIL post_stall_idle got %b expected 0", write_sig); end
  endtask

  task automatic test_scoreboard();
    issue_valid = 1; issue_rd = 5'd12;
    step();
    issue_valid = 0; rs_addr = 5'd12;
    #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL sb_rs_hazard got %b expected 1", hazard); end
    rs_addr = 5'd0; rt_addr = 5'd12; #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL sb_rt_hazard got %b expected 1", hazard); end
    rt_addr = 5'd0; rd_addr = 5'd12; #1;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL sb_rd_hazard got %b expected 1", hazard); end
    rd_addr = 5'd13; #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL sb_other_hazard got %b expected 0", hazard); end
    rd_addr = 5'd0; #1;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL sb_r0_hazard got %b expected 0", hazard); end
    rs_addr = 5'd12;
    b_valid = 1; b_addr = 5'd12; b_data = 32'h1234;
    step();
    b_valid = 0;
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL sb_buffered_hazard got %b expected 1", hazard); end
    step();
    checks++; if (write_sig !== 1'b1 || d_addr !== 5'd12) begin errors++; $display("FAIL sb_commit got %b/%0d expected 1/12", write_sig, d_addr); end
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL sb_cleared_hazard got %b expected 0", hazard); end
    issue_valid = 1; issue_rd = 5'd12;
    step();
    issue_valid = 0;
    b_valid = 1; b_addr = 5'd12; b_data = 32'h5678;
    step();
    b_valid = 0;
    issue_valid = 1; issue_rd = 5'd12;
    step();
    issue_valid = 0;
    checks++; if (write_sig !== 1'b1 || writeback_data !== 32'h5678) begin errors++; $display("FAIL sb_same_cycle_commit got %b/%h expected 1/5678", write_sig, writeback_data); end
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL sb_set_wins got %b expected 1", hazard); end
    step();
    checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL sb_set_held got %b expected 1", hazard); end
    issue_valid = 1; issue_rd = 5'd0; rs_addr = 5'd0;
    step();
    issue_valid = 0;
    checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL sb_issue_r0 got %b expected 0", hazard); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_a_only();
    test_collision();
    test_r0_and_full();
    test_starvation();
    test_scoreboard();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
